// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op and FSM
// state encodings and the default datapath width.
package muldiv_seq_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_REM  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// MUL: acc += (a[0] ? b : 0); a >>= 1; b <<= 1   (low product only)
// DIV: {acc,a} <<= 1; trial-subtract b from acc; shift quotient bit into a.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_mul_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);

  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // Single add/shift (MUL) or restoring trial subtraction (DIV) step
  always_comb begin
    rem_sh_s = {acc_i, a_i[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, b_i};
    acc_o    = acc_i;
    a_o      = a_i;
    b_o      = b_i;
    if (is_mul_i) begin
      acc_o = acc_i + (a_i[0] ? b_i : {XLEN{1'b0}});
      a_o   = {1'b0, a_i[XLEN-1:1]};
      b_o   = {b_i[XLEN-2:0], 1'b0};
    end else begin
      b_o = b_i;
      if (!diff_s[XLEN]) begin
        // No borrow: divisor fits, keep the difference and set quotient bit
        acc_o = diff_s[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_sh_s[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit beside the EX-stage ALU. Runs UNROLL
// datapath steps per cycle, stalls the pipeline until the result is ready,
// and short-circuits RISC-V divide-by-zero and signed overflow cases.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] data_o
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(STEPS - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] abs_f(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? neg_f(v) : v;
  endfunction

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_mul_s;
  logic            accept_s;
  logic            div0_s;
  logic            ovf_s;
  logic [XLEN-1:0] acc_nx_s, a_nx_s, b_nx_s;

  assign is_mul_s = (op_q == OP_MUL);

  // Chain of UNROLL single-step datapaths fed from the working registers
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [XLEN-1:0] acc_in_s, a_in_s, b_in_s;
    logic [XLEN-1:0] acc_out_s, a_out_s, b_out_s;
    if (g == 0) begin : g_first
      assign acc_in_s = acc_q;
      assign a_in_s   = a_q;
      assign b_in_s   = b_q;
    end else begin : g_next
      assign acc_in_s = g_step[g-1].acc_out_s;
      assign a_in_s   = g_step[g-1].a_out_s;
      assign b_in_s   = g_step[g-1].b_out_s;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_mul_i (is_mul_s),
      .acc_i    (acc_in_s),
      .a_i      (a_in_s),
      .b_i      (b_in_s),
      .acc_o    (acc_out_s),
      .a_o      (a_out_s),
      .b_o      (b_out_s)
    );
  end

  assign acc_nx_s = g_step[UNROLL-1].acc_out_s;
  assign a_nx_s   = g_step[UNROLL-1].a_out_s;
  assign b_nx_s   = g_step[UNROLL-1].b_out_s;

  assign accept_s = (state_q == ST_IDLE) && start_i && !flush_i;
  assign div0_s   = (op_e'(op_i) != OP_MUL) && (data2_i == ZERO);
  assign ovf_s    = ((op_e'(op_i) == OP_DIV) || (op_e'(op_i) == OP_REM)) &&
                    (data1_i == MIN_INT) && (data2_i == ALL_ONES);

  // Next-state, operand capture, iteration and sign fix-up
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = op_e'(op_i);
          acc_d  = ZERO;
          negq_d = 1'b0;
          negr_d = 1'b0;
          case (op_e'(op_i))
            OP_MUL: begin
              a_d = data2_i;
              b_d = data1_i;
            end
            OP_DIV, OP_REM: begin
              a_d    = abs_f(data1_i);
              b_d    = abs_f(data2_i);
              negq_d = data1_i[XLEN-1] ^ data2_i[XLEN-1];
              negr_d = data1_i[XLEN-1];
            end
            default: begin
              a_d = data1_i;
              b_d = data2_i;
            end
          endcase
          if (div0_s) begin
            state_d = ST_DONE;
            data_d  = (op_e'(op_i) == OP_REM) ? data1_i : ALL_ONES;
          end else if (ovf_s) begin
            state_d = ST_DONE;
            data_d  = (op_e'(op_i) == OP_REM) ? ZERO : MIN_INT;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_nx_s;
          a_d   = a_nx_s;
          b_d   = b_nx_s;
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_FIX: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          case (op_q)
            OP_MUL:  data_d = acc_q;
            OP_DIV:  data_d = negq_q ? neg_f(a_q) : a_q;
            OP_REM:  data_d = negr_q ? neg_f(acc_q) : acc_q;
            OP_DIVU: data_d = a_q;
            default: data_d = acc_q;
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State, working and output registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= CNT_ZERO;
      acc_q   <= ZERO;
      a_q     <= ZERO;
      b_q     <= ZERO;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      data_q  <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stall_o = accept_s | busy_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (UNROLL=1 main instance,
// UNROLL=4 instance for the latency comparison).
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start1, start4;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] d1, d2;

  logic        stall1, busy1, done1;
  logic [31:0] res1;
  logic        stall4, busy4, done4;
  logic [31:0] res4;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .op_i(op),
    .data1_i(d1), .data2_i(d2), .flush_i(flush),
    .stall_o(stall1), .busy_o(busy1), .done_o(done1), .data_o(res1)
  );

  muldiv_seq #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .op_i(op),
    .data1_i(d1), .data2_i(d2), .flush_i(flush),
    .stall_o(stall4), .busy_o(busy4), .done_o(done4), .data_o(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, scramble operands after acceptance, wait for done and
  // check latency (edges after the accepting edge), result and hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit on4, input int poke_at);
    int c;
    bit seen;
    op = o; d1 = a; d2 = b;
    if (on4) start4 = 1'b1;
    else     start1 = 1'b1;
    #1;
    check_eq({tag, "_stall_at_start"}, {31'd0, (on4 ? stall4 : stall1)}, 32'd1);
    tick();
    start1 = 1'b0; start4 = 1'b0;
    d1 = ~a; d2 = b ^ 32'h5A5A_5A5A; op = ~o;
    seen = 1'b0;
    c = 1;
    while (c <= 60 && !seen) begin
      start1 = (!on4 && poke_at == c);
      if (!on4 && poke_at == c) check_eq({tag, "_stall_busy"}, {31'd0, stall1}, 32'd1);
      if (on4 ? done4 : done1) seen = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    start1 = 1'b0;
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, 32'(c), 32'(lat));
    check_eq({tag, "_result"}, on4 ? res4 : res1, exp);
    tick();
    check_eq({tag, "_done_pulse"}, {31'd0, (on4 ? done4 : done1)}, 32'd0);
    check_eq({tag, "_hold"}, on4 ? res4 : res1, exp);
  endtask

  initial begin
    int dones;
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
    op = 2'b00; d1 = 32'd0; d2 = 32'd0;
    tick();
    tick();
    check_eq("rst_busy", {31'd0, busy1}, 32'd0);
    check_eq("rst_done", {31'd0, done1}, 32'd0);
    check_eq("rst_data", res1, 32'd0);
    rst = 1'b1;
    tick();
    check_eq("idle_stall", {31'd0, stall1}, 32'd0);

    // Multiply, both unroll factors
    run_op("mul_u1",  2'b00, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 34, 1'b0, 0);
    run_op("mul_u4",  2'b00, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 10, 1'b1, 0);
    run_op("mul_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34, 1'b0, 0);

    // Signed/unsigned division and remainder
    run_op("div_m7_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, 0);
    run_op("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, 0);
    run_op("divu_big",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 1'b0, 0);

    // Special cases finish one cycle after acceptance
    run_op("div_by0",  2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
    run_op("rem_by0",  2'b10, 32'd5, 32'd0, 32'd5,         1, 1'b0, 0);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
    run_op("div_ovf",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 0);
    run_op("rem_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);

    // start_i while busy is ignored
    run_op("div_poke", 2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b0, 5);
    run_op("rem_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 34, 1'b0, 0);

    // Flush mid-division
    op = 2'b01; d1 = 32'd100; d2 = 32'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    check_eq("flush_busy_before", {31'd0, busy1}, 32'd1);
    tick();
    flush = 1'b0;
    check_eq("flush_busy_after", {31'd0, busy1}, 32'd0);
    check_eq("flush_stall_after", {31'd0, stall1}, 32'd0);
    check_eq("flush_data_kept", res1, 32'd2);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) dones++;
      tick();
    end
    check_eq("flush_no_done", 32'(dones), 32'd0);
    run_op("mul_after_flush", 2'b00, 32'd6, 32'd7, 32'd42, 34, 1'b0, 0);

    // Same-cycle start and flush in IDLE
    op = 2'b00; d1 = 32'd9; d2 = 32'd9; start1 = 1'b1; flush = 1'b1;
    #1;
    check_eq("startflush_stall", {31'd0, stall1}, 32'd0);
    tick();
    start1 = 1'b0; flush = 1'b0;
    check_eq("startflush_busy", {31'd0, busy1}, 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done1) dones++;
      tick();
    end
    check_eq("startflush_no_done", 32'(dones), 32'd0);
    check_eq("startflush_data", res1, 32'd42);

    // Asynchronous reset mid-division
    op = 2'b01; d1 = 32'd100; d2 = 32'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    check_eq("prerst_busy", {31'd0, busy1}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy1}, 32'd0);
    check_eq("midrst_done", {31'd0, done1}, 32'd0);
    check_eq("midrst_data", res1, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("postrst_busy", {31'd0, busy1}, 32'd0);
    run_op("mul_after_rst", 2'b00, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 34, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
